imm_gen: RTL and testbench
==========================

# imm_gen

Immediate generator for the RV32I decode stage. It extracts the immediate field from a 32-bit instruction word according to a 3-bit format select, then sign- or zero-extends it to 32 bits. The result is registered for one cycle so it aligns with the register-file read data presented to the execute stage.

## Interface
- No parameters. Data width is fixed at 32 bits.
- Clock: one clock, `clk`. Reset: asynchronous, active-low, `rst_n`.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imm_in  input  32  raw instruction word; bit numbering follows the RISC-V spec.
- imm_sel  input  3  immediate format select (encoding below).
- in_valid  input  1  qualifies imm_in and imm_sel this cycle.
- imm_out  output  32  registered 32-bit immediate.
- out_valid  output  1  imm_out holds a result captured on the previous edge.

## Operation
Each immediate is computed combinationally from imm_in and imm_sel. Bit 31 of imm_in is the sign bit wherever sign extension applies.

imm_sel encoding:
- 000 I: sign-extend imm_in[31:20].
- 001 I-shift: zero-extend imm_in[24:20] (shamt for SLLI/SRLI/SRAI); bits 31:5 of the result = 0.
- 010 S: sign-extend {imm_in[31:25], imm_in[11:7]}.
- 011 B: sign-extend {imm_in[31], imm_in[7], imm_in[30:25], imm_in[11:8], 1'b0}; bit 0 is always 0.
- 100 U: {imm_in[31:12], 12'b0}; no extension.
- 101 J: sign-extend {imm_in[31], imm_in[19:12], imm_in[20], imm_in[30:21], 1'b0}; bit 0 is always 0.
- 110: Z format when IMM_GEN_CSR_EN is defined, otherwise reserved.
- 111: reserved.
- Reserved codes produce 32'h0000_0000. They do not raise an error and do not suppress out_valid.

Other rules:
- Opcode and funct bits in imm_in that are not part of the selected field are ignored.
- No arithmetic is performed beyond extension and concatenation. There is no overflow path.

## Timing
- Latency is one cycle. On a rising clk edge with in_valid=1, imm_out takes the decoded value and out_valid goes to 1.
- Rising edge with in_valid=0: imm_out holds its previous value and out_valid goes to 0.
- Back-to-back in_valid=1 cycles give one result per cycle, with no bubbles and no backpressure.
- Reset: while rst_n=0, imm_out=32'h0 and out_valid=0 immediately, with no clock required. This also applies to reset asserted mid-stream; any in-flight result is discarded.
- First capture is the first rising edge after rst_n deasserts with in_valid=1.
- A change of imm_sel with imm_in unchanged between cycles is treated as an independent input; no state is carried across cycles other than the output register.

## Configuration
- Macro: IMM_GEN_CSR_EN.
- Defined: imm_sel=110 is the Z (CSR uimm) format. The result is zero-extended imm_in[19:15], with bits 31:5 = 0.
- Undefined: imm_sel=110 is reserved and produces 32'h0. All other codes are identical in both builds.

## Test plan
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> imm_out=0 and out_valid=0 asynchronously; values stay cleared until the first valid edge after release.
- I and I-shift, one cycle after each edge:
  - imm_in=32'hFFB0_0000, sel=000 -> imm_out=32'hFFFF_FFFB (-5).
  - imm_in=32'h0040_0000, sel=001 -> imm_out=32'h0000_0004.
- S and B:
  - imm_in=32'hFE00_0E00, sel=010 -> imm_out=32'hFFFF_FFFC.
  - imm_in=32'h2800_0300, sel=011 -> imm_out=32'h0000_0286.
- U and J:
  - imm_in=32'h1234_5000, sel=100 -> imm_out=32'h1234_5000.
  - imm_in=32'hAAAA_A000, sel=101 -> imm_out=32'hFFFA_A2AA.
- Reserved and Z codes:
  - sel=111 with any imm_in -> imm_out=0.
  - sel=110, imm_in=32'h000F_8000, IMM_GEN_CSR_EN defined -> imm_out=32'h0000_001F.
  - Same input with the macro undefined -> imm_out=0.
- Hold and throughput:
  - Six back-to-back valid inputs -> six consecutive results with out_valid=1.
  - Then in_valid=0 -> out_valid=0 and imm_out holds the last value (32'hFFFA_A2AA).

Source files
------------

// File: rtl/imm_gen.sv
// RV32I immediate generator: decodes the selected immediate format and registers it for one cycle.
// Optional feature: define IMM_GEN_CSR_EN to decode imm_sel=110 as the Z (CSR uimm) format.
module imm_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imm_in,
  input  logic [2:0]  imm_sel,
  input  logic        in_valid,
  output logic [31:0] imm_out,
  output logic        out_valid
);

  typedef enum logic [2:0] {
    SelI     = 3'b000,
    SelShamt = 3'b001,
    SelS     = 3'b010,
    SelB     = 3'b011,
    SelU     = 3'b100,
    SelJ     = 3'b101,
    SelZ     = 3'b110,
    SelRsvd  = 3'b111
  } imm_sel_e;

  logic [31:0] w_imm;
  logic        w_sign;
  logic [31:0] r_imm;
  logic        r_valid;

  assign w_sign = imm_in[31];

  always_comb begin
    w_imm = 32'h0000_0000;
    unique case (imm_sel_e'(imm_sel))
      SelI:     w_imm = {{20{w_sign}}, imm_in[31:20]};
      SelShamt: w_imm = {27'b0, imm_in[24:20]};
      SelS:     w_imm = {{20{w_sign}}, imm_in[31:25], imm_in[11:7]};
      SelB:     w_imm = {{19{w_sign}}, imm_in[31], imm_in[7], imm_in[30:25], imm_in[11:8], 1'b0};
      SelU:     w_imm = {imm_in[31:12], 12'b0};
      SelJ:     w_imm = {{11{w_sign}}, imm_in[31], imm_in[19:12], imm_in[20], imm_in[30:21],
                         1'b0};
`ifdef IMM_GEN_CSR_EN
      SelZ:     w_imm = {27'b0, imm_in[19:15]};
`else
      SelZ:     w_imm = 32'h0000_0000;
`endif
      SelRsvd:  w_imm = 32'h0000_0000;
      default:  w_imm = 32'h0000_0000;
    endcase
  end

  // imm_out holds its last value on idle cycles; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_imm <= w_imm;
      end
    end
  end

  assign imm_out   = r_imm;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_imm_gen.sv
// Directed scoreboard bench for imm_gen: expected results queued at drive time, checked after
// the capturing edge with immediate assertions.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imm_in = 32'h0;
  logic [2:0]  imm_sel = 3'b000;
  logic        in_valid = 1'b0;
  logic [31:0] imm_out;
  logic        out_valid;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_d = 32'h0;

  imm_gen u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .imm_in   (imm_in),
    .imm_sel  (imm_sel),
    .in_valid (in_valid),
    .imm_out  (imm_out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp_d, input logic exp_v);
    n_total++;
    assert (imm_out === exp_d && out_valid === exp_v) n_pass++;
    else $error("FAIL %s: imm_out=%h out_valid=%b, expected imm_out=%h out_valid=%b",
                tag, imm_out, out_valid, exp_d, exp_v);
  endtask

  // Drive one cycle of stimulus; queue the expected result and check it one edge later.
  task automatic drive(input string tag, input logic v, input logic [2:0] sel,
                       input logic [31:0] din, input logic [31:0] exp_d);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    imm_sel  = sel;
    imm_in   = din;
    if (v) last_d = exp_d;
    sb_q.push_back('{v: v, d: last_d});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: scoreboard empty, expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      check(tag, e.d, e.v);
    end
  endtask

  initial begin
    // Reset held with a clock running and in_valid high: outputs stay cleared.
    in_valid = 1'b1;
    imm_in   = 32'hFFB0_0000;
    #1;
    check("reset_initial", 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 32'h0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_idle", 32'h0, 1'b0);

    // Six back-to-back valid inputs, one per format.
    drive("fmt_i",     1'b1, 3'b000, 32'hFFB0_0000, 32'hFFFF_FFFB);
    drive("fmt_shamt", 1'b1, 3'b001, 32'h0040_0000, 32'h0000_0004);
    drive("fmt_s",     1'b1, 3'b010, 32'hFE00_0E00, 32'hFFFF_FFFC);
    drive("fmt_b",     1'b1, 3'b011, 32'h2800_0300, 32'h0000_0286);
    drive("fmt_u",     1'b1, 3'b100, 32'h1234_5000, 32'h1234_5000);
    drive("fmt_j",     1'b1, 3'b101, 32'hAAAA_A000, 32'hFFFA_A2AA);

    // Idle cycles hold the last value with out_valid low.
    drive("hold_1", 1'b0, 3'b000, 32'h1234_5678, 32'h0);
    drive("hold_2", 1'b0, 3'b011, 32'hFFFF_FFFF, 32'h0);

    // Extra fields and opcode bits must be ignored.
    drive("i_pos_noise",  1'b1, 3'b000, 32'h7FF0_0FFF, 32'h0000_07FF);
    drive("shamt_noise",  1'b1, 3'b001, 32'hFE0F_FFFF, 32'h0000_0000);
    drive("b_neg",        1'b1, 3'b011, 32'h8000_0080, 32'hFFFF_F800);
    drive("j_neg_min",    1'b1, 3'b101, 32'h8000_0000, 32'hFFF0_0000);
    drive("u_all_ones",   1'b1, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_F000);

    // Reserved and Z codes; a reserved code still raises out_valid.
    drive("rsvd_111", 1'b1, 3'b111, 32'hFFFF_FFFF, 32'h0);
`ifdef IMM_GEN_CSR_EN
    drive("z_110", 1'b1, 3'b110, 32'h000F_8000, 32'h0000_001F);
`else
    drive("z_110", 1'b1, 3'b110, 32'h000F_8000, 32'h0);
`endif

    // Same imm_in under a new imm_sel is decoded independently.
    drive("sel_change_i", 1'b1, 3'b000, 32'hAAAA_A000, 32'hFFFF_FAAA);
    drive("sel_change_j", 1'b1, 3'b101, 32'hAAAA_A000, 32'hFFFA_A2AA);

    // Mid-stream asynchronous reset with in_valid high.
    @(negedge clk);
    in_valid = 1'b1;
    imm_sel  = 3'b100;
    imm_in   = 32'h1234_5000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_mid_edge", 32'h0, 1'b0);
    sb_q.delete();
    last_d = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_mid_release", 32'h0, 1'b0);
    drive("first_after_reset", 1'b1, 3'b100, 32'h1234_5000, 32'h1234_5000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary, expected completion");
    $fatal(1, "timeout");
  end

endmodule
